// File: rtl/traffic_pkg.sv
// Shared types and helpers for the two-approach traffic phase scheduler.
//   phase_e      : controller state code, also exported on the Phase port
//   LIGHT_*      : two-bit lamp driver codes
//   to_bcd()     : binary 0..99 to two packed BCD digits {tens, units}
package traffic_pkg;

    typedef enum logic [2:0] {
        INIT_RED = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        RED_AB   = 3'd3,
        B_GREEN  = 3'd4,
        B_YELLOW = 3'd5,
        RED_BA   = 3'd6
    } phase_e;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    // Valid for 0..99. Used both on parameters at elaboration and on the
    // runtime extension length, which is bounded by GREEN_MAX <= 99.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] tens;
        logic [6:0] units;
        tens  = v / 7'd10;
        units = v % 7'd10;
        return {tens[3:0], units[3:0]};
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter used as the phase timer.
//   clk, rst_n : clock, asynchronous active-low reset (loads RST_VAL)
//   load       : synchronous load of load_val, takes priority over dec
//   load_val   : BCD value {tens, units}
//   dec        : decrement by one (held at 00, which a phase never reaches)
//   cnt        : current BCD value
//   is_one     : cnt == 01, marks the final second of a phase
module bcd_down_counter #(
    parameter logic [7:0] RST_VAL = 8'h02
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] cnt,
    output logic       is_one
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && cnt_q != 8'h00) begin
            if (cnt_q[3:0] == 4'd0) begin
                cnt_d = {cnt_q[7:4] - 4'd1, 4'd9};
            end else begin
                cnt_d = {cnt_q[7:4], cnt_q[3:0] - 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign is_one = (cnt_q == 8'h01);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Right-of-way sequencer for a two-approach intersection: timed
// green/yellow/all-red cycle, traffic-actuated green extensions, latched
// call buttons and per-approach two-digit BCD countdown displays.
//   CLK, R             : clock, asynchronous active-low reset
//   A, B               : call buttons
//   A_Traffic,B_Traffic: vehicle presence (level), looked at on ending ticks
//   A_Time_H/L, B_Time_H/L : BCD countdown digits per approach
//   A_Light, B_Light   : lamp codes (00 red, 01 yellow, 10 green)
//   Phase              : current state code
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 10,
    parameter int unsigned GREEN_MIN = 20,
    parameter int unsigned GREEN_MAX = 60,
    parameter int unsigned EXT       = 10,
    parameter int unsigned YELLOW    = 3,
    parameter int unsigned ALL_RED   = 2
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       A,
    input  logic       B,
    input  logic       A_Traffic,
    input  logic       B_Traffic,
    output logic [3:0] A_Time_L,
    output logic [3:0] A_Time_H,
    output logic [3:0] B_Time_L,
    output logic [3:0] B_Time_H,
    output logic [1:0] A_Light,
    output logic [1:0] B_Light,
    output logic [2:0] Phase
);

    localparam int          PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
    localparam logic [6:0]  GMAX7    = 7'(GREEN_MAX);
    localparam logic [6:0]  EXT7     = 7'(EXT);
    localparam logic [7:0]  GMIN_BCD = to_bcd(7'(GREEN_MIN));
    localparam logic [7:0]  YEL_BCD  = to_bcd(7'(YELLOW));
    localparam logic [7:0]  RED_BCD  = to_bcd(7'(ALL_RED));

    phase_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [6:0]    elapsed_q, elapsed_d;
    logic          req_a_q, req_a_d;
    logic          req_b_q, req_b_d;
    logic [1:0]    a_light_q, a_light_d;
    logic [1:0]    b_light_q, b_light_d;

    logic          tick;
    logic          ending;
    logic          cnt_is_one;
    logic [7:0]    cnt;
    logic [7:0]    cnt_val;
    logic [6:0]    elapsed_now;
    logic [6:0]    green_left;
    logic [6:0]    ext_len;
    logic          ext_ok_a;
    logic          ext_ok_b;
    logic          in_green;
    logic          enter_a;
    logic          enter_b;
    logic          show_both;

    bcd_down_counter #(.RST_VAL(RED_BCD)) u_phase_cnt (
        .clk      (CLK),
        .rst_n    (R),
        .load     (ending),
        .load_val (cnt_val),
        .dec      (tick),
        .cnt      (cnt),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        tick    = (presc_q == PRE_TOP);
        presc_d = tick ? '0 : presc_q + 1'b1;
        ending  = tick && cnt_is_one;

        // Elapsed including the tick being consumed now, so the decision at
        // the end of the minimum green sees exactly GREEN_MIN seconds.
        elapsed_now = elapsed_q + 7'd1;
        green_left  = GMAX7 - elapsed_now;
        ext_len     = (green_left < EXT7) ? green_left : EXT7;
        ext_ok_a    = A_Traffic && !B_Traffic && !req_b_q && (elapsed_now < GMAX7);
        ext_ok_b    = B_Traffic && !A_Traffic && !req_a_q && (elapsed_now < GMAX7);

        state_d = state_q;
        cnt_val = RED_BCD;
        if (ending) begin
            case (state_q)
                INIT_RED: begin state_d = A_GREEN;  cnt_val = GMIN_BCD; end
                A_GREEN: begin
                    if (ext_ok_a) begin
                        cnt_val = to_bcd(ext_len);
                    end else begin
                        state_d = A_YELLOW;
                        cnt_val = YEL_BCD;
                    end
                end
                A_YELLOW: begin state_d = RED_AB;   cnt_val = RED_BCD;  end
                RED_AB:   begin state_d = B_GREEN;  cnt_val = GMIN_BCD; end
                B_GREEN: begin
                    if (ext_ok_b) begin
                        cnt_val = to_bcd(ext_len);
                    end else begin
                        state_d = B_YELLOW;
                        cnt_val = YEL_BCD;
                    end
                end
                B_YELLOW: begin state_d = RED_BA;   cnt_val = RED_BCD;  end
                RED_BA:   begin state_d = A_GREEN;  cnt_val = GMIN_BCD; end
                default:  begin state_d = INIT_RED; cnt_val = RED_BCD;  end
            endcase
        end

        in_green = (state_q == A_GREEN) || (state_q == B_GREEN);
        enter_a  = (state_d == A_GREEN) && (state_q != A_GREEN);
        enter_b  = (state_d == B_GREEN) && (state_q != B_GREEN);

        elapsed_d = elapsed_q;
        if (enter_a || enter_b) begin
            elapsed_d = '0;
        end else if (tick && in_green) begin
            elapsed_d = elapsed_now;
        end

        // Clear on green entry wins over a coincident press.
        req_a_d = (req_a_q || (A && a_light_q != LIGHT_GREEN)) && !enter_a;
        req_b_d = (req_b_q || (B && b_light_q != LIGHT_GREEN)) && !enter_b;

        a_light_d = LIGHT_RED;
        b_light_d = LIGHT_RED;
        case (state_d)
            A_GREEN:  a_light_d = LIGHT_GREEN;
            A_YELLOW: a_light_d = LIGHT_YELLOW;
            B_GREEN:  b_light_d = LIGHT_GREEN;
            B_YELLOW: b_light_d = LIGHT_YELLOW;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q   <= INIT_RED;
            presc_q   <= '0;
            elapsed_q <= '0;
            req_a_q   <= 1'b0;
            req_b_q   <= 1'b0;
            a_light_q <= LIGHT_RED;
            b_light_q <= LIGHT_RED;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            elapsed_q <= elapsed_d;
            req_a_q   <= req_a_d;
            req_b_q   <= req_b_d;
            a_light_q <= a_light_d;
            b_light_q <= b_light_d;
        end
    end

    // During the all-red states both approaches count down the clearance.
    assign show_both = (state_q == INIT_RED) || (state_q == RED_AB) || (state_q == RED_BA);

    assign {A_Time_H, A_Time_L} = (show_both || a_light_q != LIGHT_RED) ? cnt : 8'h00;
    assign {B_Time_H, B_Time_L} = (show_both || b_light_q != LIGHT_RED) ? cnt : 8'h00;
    assign A_Light = a_light_q;
    assign B_Light = b_light_q;
    assign Phase   = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

    logic       CLK = 1'b0;
    logic       R   = 1'b0;
    logic       A   = 1'b0;
    logic       B   = 1'b0;
    logic       A_Traffic = 1'b0;
    logic       B_Traffic = 1'b0;
    logic [3:0] A_Time_L, A_Time_H, B_Time_L, B_Time_H;
    logic [1:0] A_Light, B_Light;
    logic [2:0] Phase;

    traffic_phase_scheduler dut (
        .CLK       (CLK),
        .R         (R),
        .A         (A),
        .B         (B),
        .A_Traffic (A_Traffic),
        .B_Traffic (B_Traffic),
        .A_Time_L  (A_Time_L),
        .A_Time_H  (A_Time_H),
        .B_Time_L  (B_Time_L),
        .B_Time_H  (B_Time_H),
        .A_Light   (A_Light),
        .B_Light   (B_Light),
        .Phase     (Phase)
    );

    always #5 CLK = ~CLK;

    int edges = 0;
    always @(posedge CLK) edges++;

    typedef struct {
        int          stamp;
        string       tag;
        logic [22:0] exp;
    } item_t;

    item_t sb[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    base  = 0;

    // {Phase, A_Light, B_Light, A_H, A_L, B_H, B_L}
    wire [22:0] obs = {Phase, A_Light, B_Light, A_Time_H, A_Time_L, B_Time_H, B_Time_L};

    task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    localparam logic [1:0] RD = 2'b00, YL = 2'b01, GR = 2'b10;

    function automatic logic [22:0] ev(input int ph, input logic [1:0] al, input logic [1:0] bl,
                                       input int ad, input int bd);
        return {3'(ph), al, bl, 4'(ad / 10), 4'(ad % 10), 4'(bd / 10), 4'(bd % 10)};
    endfunction

    // Expect a snapshot k clock edges after the latest reset release.
    task automatic expect_at(input int k, input string tag, input logic [22:0] v);
        item_t it;
        it.stamp = base + k;
        it.tag   = tag;
        it.exp   = v;
        sb.push_back(it);
    endtask

    always @(negedge CLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].stamp == edges) begin
                chk(sb[i].tag, obs, sb[i].exp);
                sb.delete(i);
            end else if (sb[i].stamp < edges) begin
                chk({sb[i].tag, "_missed"}, 23'(edges), 23'(sb[i].stamp));
                sb.delete(i);
            end
        end
    end

    task automatic at(input int k);
        while (edges < base + k) @(negedge CLK);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 23'(sb.size()), 23'd0);
            sb.delete();
        end
    endtask

    task automatic do_reset(input int cycles, input string tag);
        @(negedge CLK);
        R = 1'b0;
        #1 chk(tag, obs, ev(0, RD, RD, 2, 2));
        repeat (cycles) @(negedge CLK);
        R = 1'b1;
        base = edges;
    endtask

    task automatic press(input logic is_a);
        if (is_a) A = 1'b1; else B = 1'b1;
        @(negedge CLK);
        A = 1'b0;
        B = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset hold, then free-running cycle with all inputs low.
        repeat (40) @(negedge CLK);
        #1 chk("rst_hold", obs, ev(0, RD, RD, 2, 2));
        @(negedge CLK);
        R = 1'b1;
        base = edges;
        expect_at(19,  "init_last",  ev(0, RD, RD, 1, 1));
        expect_at(20,  "a_green_in", ev(1, GR, RD, 20, 0));
        expect_at(30,  "a_green_19", ev(1, GR, RD, 19, 0));
        expect_at(219, "a_green_01", ev(1, GR, RD, 1, 0));
        expect_at(220, "a_yel_in",   ev(2, YL, RD, 3, 0));
        expect_at(250, "red_ab_in",  ev(3, RD, RD, 2, 2));
        expect_at(270, "b_green_in", ev(4, RD, GR, 0, 20));
        expect_at(470, "b_yel_in",   ev(5, RD, YL, 0, 3));
        expect_at(500, "red_ba_in",  ev(6, RD, RD, 2, 2));
        expect_at(520, "cycle_wrap", ev(1, GR, RD, 20, 0));
        wait_drain();

        // Held A traffic: four extensions, yellow at exactly 60 s.
        do_reset(3, "rst_t3");
        A_Traffic = 1'b1;
        expect_at(220, "ext1",      ev(1, GR, RD, 10, 0));
        expect_at(320, "ext2",      ev(1, GR, RD, 10, 0));
        expect_at(420, "ext3",      ev(1, GR, RD, 10, 0));
        expect_at(520, "ext4",      ev(1, GR, RD, 10, 0));
        expect_at(619, "ext_last",  ev(1, GR, RD, 1, 0));
        expect_at(620, "ext_max_y", ev(2, YL, RD, 3, 0));
        wait_drain();

        // Call cut by a one-cycle B press; req_B cleared at B green entry.
        do_reset(3, "rst_t4");
        A_Traffic = 1'b1;
        expect_at(220, "cut_a_yel",  ev(2, YL, RD, 3, 0));
        expect_at(270, "cut_b_grn",  ev(4, RD, GR, 0, 20));
        expect_at(470, "cut_b_yel",  ev(5, RD, YL, 0, 3));
        expect_at(720, "cut_a_ext",  ev(1, GR, RD, 10, 0));
        at(70);
        press(1'b0);
        wait_drain();

        // Contention: both sensors active, no extensions.
        do_reset(3, "rst_t5");
        A_Traffic = 1'b1;
        B_Traffic = 1'b1;
        expect_at(220, "cont_a_yel", ev(2, YL, RD, 3, 0));
        expect_at(470, "cont_b_yel", ev(5, RD, YL, 0, 3));
        expect_at(720, "cont_a_yl2", ev(2, YL, RD, 3, 0));
        wait_drain();

        // B extends on its own traffic.
        do_reset(3, "rst_t7");
        A_Traffic = 1'b0;
        B_Traffic = 1'b1;
        expect_at(220, "bx_a_yel", ev(2, YL, RD, 3, 0));
        expect_at(470, "bx_b_ext", ev(4, RD, GR, 0, 10));
        wait_drain();

        // Pending A call blocks the B extension.
        do_reset(3, "rst_t8");
        B_Traffic = 1'b1;
        expect_at(470, "acall_b_yel", ev(5, RD, YL, 0, 3));
        at(300);
        press(1'b1);
        wait_drain();

        // Reset mid-B_GREEN, then restart from INIT_RED.
        do_reset(3, "rst_t6a");
        A_Traffic = 1'b0;
        B_Traffic = 1'b1;
        expect_at(310, "pre_rst_b", ev(4, RD, GR, 0, 16));
        at(300);
        press(1'b1);
        at(350);
        do_reset(10, "rst_mid_b");
        A_Traffic = 1'b1;
        B_Traffic = 1'b0;
        expect_at(19,  "rs_init",  ev(0, RD, RD, 1, 1));
        expect_at(20,  "rs_a_grn", ev(1, GR, RD, 20, 0));
        expect_at(220, "rs_a_ext", ev(1, GR, RD, 10, 0));
        wait_drain();

        // A B call latched before reset must not cut the next A green.
        do_reset(3, "rst_t9a");
        at(70);
        press(1'b0);
        at(100);
        do_reset(5, "rst_t9b");
        A_Traffic = 1'b1;
        expect_at(220, "rs_req_b_lost", ev(1, GR, RD, 10, 0));
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

- Sequences right-of-way between approaches A and B of a two-way intersection.
- Runs a timed green / yellow / all-red phase cycle and grants traffic-actuated green extensions.
- Latches call buttons and drives two-digit BCD countdown displays per approach.
- Sits between the sensor/button inputs and the lamp drivers and displays, replacing a fixed-time sequencer.

## Interface
Parameters:
- TICK_DIV, 10: CLK cycles per one-second tick. Minimum 2.
- GREEN_MIN, 20: guaranteed green seconds per approach.
- GREEN_MAX, 60: ceiling on total green seconds per approach, including extensions. Must be at most 99 and at least GREEN_MIN.
- EXT, 10: seconds added per granted extension.
- YELLOW, 3: yellow seconds.
- ALL_RED, 2: all-red clearance seconds.

Ports:
- CLK, in, 1: single clock, rising edge.
- R, in, 1: reset, asynchronous, active-low.
- A, in, 1: call button, approach A.
- B, in, 1: call button, approach B.
- A_Traffic, in, 1: vehicle presence sensor, approach A. Level signal.
- B_Traffic, in, 1: vehicle presence sensor, approach B. Level signal.
- A_Time_L, out, 4: BCD units digit of the approach A countdown.
- A_Time_H, out, 4: BCD tens digit of the approach A countdown.
- B_Time_L, out, 4: BCD units digit of the approach B countdown.
- B_Time_H, out, 4: BCD tens digit of the approach B countdown.
- A_Light, out, 2: approach A lamp. 00 red, 01 yellow, 10 green; 11 is never driven.
- B_Light, out, 2: approach B lamp, same encoding.
- Phase, out, 3: current state code, for debug and the bench.

## Operation
States, in cycle order:
- INIT_RED
- A_GREEN
- A_YELLOW
- RED_AB
- B_GREEN
- B_YELLOW
- RED_BA, which returns to A_GREEN.

Phase countdown:
- On entry, the phase counter loads the state duration: GREEN_MIN, YELLOW or ALL_RED. INIT_RED loads ALL_RED.
- Each tick decrements the counter.
- On the tick where the counter equals 1, the state ends: the next state is entered and its duration loaded in the same cycle. The counter therefore never displays 00 inside a phase.

Green extension, decided on the ending tick of an X_GREEN state (X is the green approach, Y the other):
- An extension is granted only when all of these hold:
  - X_Traffic = 1
  - Y_Traffic = 0
  - request latch req_Y = 0
  - elapsed green for X is less than GREEN_MAX
- When granted, the counter reloads with min(EXT, GREEN_MAX − elapsed) and the state is held.
- Otherwise the state goes to X_YELLOW.
- Elapsed green is a 7-bit binary register: cleared on green entry, incremented each tick while green.

Request latches:
- req_A sets on A = 1 while A_Light ≠ green. It clears on the cycle of entry into A_GREEN.
- If set and clear coincide, clear wins. Pressing A while A is green has no effect.
- req_B follows the same rules with B and B_GREEN.

Display rules:
- The display of the approach in green or yellow shows the phase counter.
- The red approach's display shows 00, except during INIT_RED, RED_AB and RED_BA, when both displays show the counter.
- All digits are valid BCD, 0–9.

Reset (R = 0, asynchronous):
- State INIT_RED, counter ALL_RED, prescaler 0, elapsed 0, req_A and req_B 0.
- Both lights 00. Both displays show ALL_RED (defaults: H = 0, L = 2). Phase = INIT_RED.
- Reset asserted mid-phase aborts immediately.
- After reset the cycle always resumes with A_GREEN.

## Timing
- Prescaler counts 0 to TICK_DIV−1. It emits a one-cycle tick on the cycle it wraps. The first tick arrives TICK_DIV cycles after R deasserts.
- Outputs are registered. Lights, displays and Phase update on the CLK edge following the tick cycle.
- Buttons and sensors are sampled synchronously and need no pulse-width minimum beyond one cycle. Sensors are evaluated only at the ending tick.
- Decision at an ending tick, after the edge:
  - A_Light/B_Light = 10/00 and counter 10 means an extension was granted.
  - 01/00 and counter YELLOW means no extension.
- Nominal cycle with no extensions: 2 × (GREEN_MIN + YELLOW + ALL_RED) = 50 s = 500 cycles at default parameters.

## Structure
- Package traffic_pkg holds:
  - the state enum: INIT_RED = 0 through RED_BA = 6
  - light codes LIGHT_RED, LIGHT_YELLOW, LIGHT_GREEN
  - a function converting a decimal constant to two BCD digits, used to convert parameters at elaboration
- Sub-module bcd_down_counter: 2-digit BCD counter with synchronous load, tick-enabled decrement and an is_one flag. The scheduler instantiates it once as the phase counter.
- Prescaler, FSM, request latches and display muxing live in traffic_phase_scheduler.

## Test plan
Defaults throughout, 10 ns clock.
1. Reset: hold R = 0 for 400 ns → lights 00/00, all displays 0/2, Phase = 0. Release → 20 cycles later A_Light = 10, A_Time H/L = 2/0, B_Time = 00.
2. Free-running, all inputs 0:
   - A green 200 cycles, yellow 30, all-red 20, then B_GREEN with B_Time = 20.
   - Full cycle 500 cycles back to A_GREEN.
3. Extension: A_Traffic = 1 held, B_Traffic = 0 → A_Time reloads to 10 at 20 s, 30 s, 40 s and 50 s. A_YELLOW is entered at 60 s exactly; no fifth extension.
4. Call cut: A_Traffic = 1, pulse B for one cycle at 5 s into A green → no extension; A_YELLOW at 20 s. req_B clears on B_GREEN entry, so the next A green can extend.
5. Contention: A_Traffic = B_Traffic = 1 → no extension for either approach; each green lasts 20 s.
6. Reset mid-B_GREEN, 10 cycles low → immediate 00/00 with displays 02. On release the sequence restarts INIT_RED then A_GREEN, and pre-reset requests are lost.
